// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array skew feeder.
//   - feeder_state_e : feeder FSM state encoding
//   - DEFAULT_DATA_WIDTH / DEFAULT_CTRL_WIDTH : default lane and control widths
//   - lane_lsb()     : bit offset of a lane inside a packed multi-lane vector
// Optional feature macro used by the feeder top: SA_FEEDER_BEAT_CNT_EN.
// -----------------------------------------------------------------------------
package sa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } feeder_state_e;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_CTRL_WIDTH = 3;

   // Lane r of a packed vector occupies bits [lane_lsb(r, w) +: w].
   function automatic int unsigned lane_lsb(input int unsigned lane,
                                            input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sa_skew_line.sv
// -----------------------------------------------------------------------------
// sa_skew_line
// Fixed-depth delay line for one {valid, data} lane of the skew feeder.
// DEPTH = 0 is a combinational pass-through (used by lane 0).
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous reset, active-low; clears every stage
//   valid_i  lane valid entering the line
//   data_i   lane word entering the line
//   valid_o  lane valid after DEPTH cycles
//   data_o   lane word after DEPTH cycles
// -----------------------------------------------------------------------------
module sa_skew_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   if (DEPTH == 0) begin : g_pass
      assign valid_o = valid_i;
      assign data_o  = data_i;
      // Clock and reset have no load in the pass-through configuration.
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
   end else begin : g_delay
      // Stage 0 is the newest entry, stage DEPTH-1 drives the output.
      logic [WIDTH:0] line_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
         end else begin
            line_q[0] <= {valid_i, data_i};
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
         end
      end

      assign {valid_o, data_o} = line_q[DEPTH-1];
   end

endmodule

// File: rtl/sa_skew_feeder.sv
// -----------------------------------------------------------------------------
// sa_skew_feeder
// Left-edge feeder of the systolic array. Accepts one NUM_ROWS-lane vector per
// beat and skews it so lane r reaches the array r cycles after lane 0. Cycles
// without an accepted beat inject zero bubbles, since array cells never stall.
// After the last beat of a block the skew lines drain and done pulses once,
// aligned with the last beat leaving lane NUM_ROWS-1.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid. in_last and
// in_ctrl are only looked at when a beat transfers.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid, in_ready, in_data, in_ctrl, in_last : upstream beat interface
//   left_out, lane_valid : skewed lanes to the array left inputs
//   ctrl_out             : control word aligned with lane 0
//   busy, done           : block status
//   beat_count           : accepted beats in the current block
//                          (only when SA_FEEDER_BEAT_CNT_EN is defined)
// -----------------------------------------------------------------------------
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH,
   parameter int NUM_ROWS   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0]          in_ctrl,
   input  logic                           in_last,
   output logic [NUM_ROWS*DATA_WIDTH-1:0] left_out,
   output logic [NUM_ROWS-1:0]            lane_valid,
   output logic [CTRL_WIDTH-1:0]          ctrl_out,
   output logic                           busy,
`ifdef SA_FEEDER_BEAT_CNT_EN
   output logic [15:0]                    beat_count,
`endif
   output logic                           done
);

   // Drain counter runs NUM_ROWS-2 .. 0, so NUM_ROWS-1 drain cycles in total.
   localparam int CNT_W = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((NUM_ROWS >= 2) ? NUM_ROWS - 2 : 0);

   feeder_state_e state_q, state_d;
   logic [CNT_W-1:0] drain_q, drain_d;

   logic accept;

   // Input register stage: the beat (or a zero bubble) for lane 0 timing.
   logic [NUM_ROWS*DATA_WIDTH-1:0] stage_q;
   logic                           stage_v_q;
   logic [CTRL_WIDTH-1:0]          ctrl_q;

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_STREAM);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign ctrl_out = ctrl_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q   <= '0;
         stage_v_q <= 1'b0;
         ctrl_q    <= '0;
      end else begin
         stage_v_q <= accept;
         stage_q   <= accept ? in_data : '0;
         ctrl_q    <= accept ? in_ctrl : '0;
      end
   end

   // Lane r gets r extra cycles of delay behind the shared input stage.
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
      localparam int LSB = lane_lsb(r, DATA_WIDTH);
      sa_skew_line #(
         .DEPTH (r),
         .WIDTH (DATA_WIDTH)
      ) u_line (
         .clk_i   (clk),
         .rst_ni  (rst),
         .valid_i (stage_v_q),
         .data_i  (stage_q[LSB +: DATA_WIDTH]),
         .valid_o (lane_valid[r]),
         .data_o  (left_out[LSB +: DATA_WIDTH])
      );
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE, ST_STREAM: begin
            if (accept) begin
               if (in_last) begin
                  // A single-lane array has nothing to drain.
                  if (NUM_ROWS == 1) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_DRAIN;
                     drain_d = DRAIN_LOAD;
                  end
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) state_d = ST_DONE;
            else               drain_d = drain_q - CNT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef SA_FEEDER_BEAT_CNT_EN
   // ------------------------------------------------------- beat counter
   logic [15:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (state_q == ST_DONE)                        beat_cnt_d = '0;
      else if (accept && (beat_cnt_q != 16'hFFFF))   beat_cnt_d = beat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) beat_cnt_q <= '0;
      else      beat_cnt_q <= beat_cnt_d;
   end

   assign beat_count = beat_cnt_q;
`endif

endmodule
